// File: rtl/gpio_bridge_pkg.sv
// Shared types and constants for the CPU-to-GPIO register bridge.
package gpio_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [31:0] GPIO_BASE_ADDR = 32'h2000_0000;
    localparam logic [31:0] GPIO_ADDR_MASK = 32'hFFFF_FFF0;

    localparam logic [3:0] WSTRB_NONE = 4'h0;
    localparam logic [3:0] WSTRB_FULL = 4'hF;

    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;

endpackage

// File: rtl/gpio_bus_bridge_if.sv
// CPU memory-mapped request/response bus (valid/ready, byte strobes).
interface gpio_bus_bridge_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/gpio_byte_merge.sv
// Per-byte mux: lanes with a strobe take the new word, the rest keep the old word.
module gpio_byte_merge #(
    parameter int NUM_LANES = 4,
    parameter int VEC_W     = 8
) (
    input  logic [NUM_LANES-1:0][VEC_W-1:0] old_word,
    input  logic [NUM_LANES-1:0][VEC_W-1:0] new_word,
    input  logic [NUM_LANES-1:0]            wstrb,
    output logic [NUM_LANES-1:0][VEC_W-1:0] merged
);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign merged[i] = wstrb[i] ? new_word[i] : old_word[i];
    end

endmodule

// File: rtl/gpio_bus_bridge.sv
// Bridges byte-strobed CPU accesses onto full-word GPIO register strobes,
// turning partial writes into a read-modify-write.
module gpio_bus_bridge
    import gpio_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = GPIO_BASE_ADDR,
    parameter logic [31:0] ADDR_MASK = GPIO_ADDR_MASK
) (
    input  logic                clk,
    input  logic                resetn,
    gpio_bus_bridge_if.slave    mem,
    output logic                gpio_write_en,
    output logic                gpio_read_en,
    output logic [31:0]         gpio_wdata,
    input  logic [31:0]         gpio_rdata
);

    state_e      state_q, state_d;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        rmw_q;
    logic        is_rd_q;
    logic        hit;
    logic        accept;
    logic [31:0] merged;
    logic [31:0] wdata_d;

    assign hit    = mem.mem_valid && ((mem.mem_addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
    assign accept = (state_q == IDLE) && hit;

    // Old bytes come straight from the read issued in the READ cycle.
    gpio_byte_merge #(
        .NUM_LANES (NUM_LANES),
        .VEC_W     (VEC_W)
    ) u_merge (
        .old_word (gpio_rdata),
        .new_word (wdata_q),
        .wstrb    (wstrb_q),
        .merged   (merged)
    );

    always_comb begin
        state_d = state_q;
        wdata_d = merged;
        case (state_q)
            IDLE: begin
                wdata_d = mem.mem_wdata;
                if (hit) begin
                    state_d = (mem.mem_wstrb == WSTRB_FULL) ? WRITE : READ;
                end
            end
            READ:    state_d = rmw_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every output is registered off the next state, so each strobe is high
    // exactly during the cycle its state is occupied.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= IDLE;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rmw_q         <= 1'b0;
            is_rd_q       <= 1'b0;
            gpio_read_en  <= 1'b0;
            gpio_write_en <= 1'b0;
            gpio_wdata    <= '0;
            mem.mem_ready <= 1'b0;
            mem.mem_rdata <= '0;
        end else begin
            state_q       <= state_d;
            gpio_read_en  <= (state_d == READ);
            gpio_write_en <= (state_d == WRITE);
            gpio_wdata    <= (state_d == WRITE) ? wdata_d : 32'h0;
            mem.mem_ready <= (state_d == RESP);
            mem.mem_rdata <= (state_d == RESP && state_q == READ && is_rd_q) ? gpio_rdata : 32'h0;
            if (accept) begin
                wdata_q <= mem.mem_wdata;
                wstrb_q <= mem.mem_wstrb;
                is_rd_q <= (mem.mem_wstrb == WSTRB_NONE);
                rmw_q   <= (mem.mem_wstrb != WSTRB_NONE) && (mem.mem_wstrb != WSTRB_FULL);
            end
        end
    end

endmodule
